// File: rtl/meter_pkg.sv
// Shared types and credit arithmetic for the parking-meter session controller.
package meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FUND    = 2'd1,
        RUN     = 2'd2,
        EXPIRED = 2'd3
    } meter_state_t;

    localparam int CREDIT_W = 8;
    localparam int CALC_W   = CREDIT_W + 1;

    function automatic logic [CALC_W-1:0] sat_add(
        input logic [CALC_W-1:0] credit,
        input logic [CALC_W-1:0] delta,
        input logic [CALC_W-1:0] lim
    );
        logic [CALC_W:0] sum;
        sum = {1'b0, credit} + {1'b0, delta};
        if (sum > {1'b0, lim}) begin
            return lim;
        end
        return sum[CALC_W-1:0];
    endfunction

endpackage

// File: rtl/meter_session_ctrl_if.sv
// Switch inputs and display/status outputs of the meter session controller.
interface meter_session_ctrl_if;
    import meter_pkg::*;

    logic [2:0]          sw_coin;
    logic                sw_start;
    logic [CREDIT_W-1:0] time_val;
    logic [1:0]          state_o;
    logic                running;
    logic                expired;
    logic                blank;

    modport master (
        output sw_coin, sw_start,
        input  time_val, state_o, running, expired, blank
    );

    modport slave (
        input  sw_coin, sw_start,
        output time_val, state_o, running, expired, blank
    );
endinterface

// File: rtl/edge_sync.sv
// 2-flop synchroniser per bit plus rising-edge detect on the synchronised level.
// Rise is a one-cycle pulse while the synchronised level is newly high.
module edge_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] lvl_o,
    output logic [W-1:0] rise_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;
    logic [1:0]   settle_q;

    // prev_q starts all-ones and only tracks sync_q once the reset zeros have
    // flushed out, so a switch held high through reset needs a low first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= '0;
            sync_q   <= '0;
            prev_q   <= '1;
            settle_q <= '0;
        end else begin
            meta_q   <= din_i;
            sync_q   <= meta_q;
            settle_q <= {settle_q[0], 1'b1};
            if (settle_q[1]) begin
                prev_q <= sync_q;
            end
        end
    end

    assign lvl_o  = sync_q;
    assign rise_o = sync_q & ~prev_q;
endmodule

// File: rtl/meter_session_ctrl.sv
// Parking-meter session FSM: sole owner of the seconds credit, countdown and expiry flash.
// Coin events reach time_val 3 cycles after the raw switch edge; all outputs come from registers.
module meter_session_ctrl
    import meter_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_DIV  = CLK_HZ,
    parameter int BLINK_DIV = CLK_HZ / 2,
    parameter int COIN0_SEC = 5,
    parameter int COIN1_SEC = 10,
    parameter int COIN2_SEC = 25,
    parameter int MAX_SEC   = 99
) (
    input logic                 clk,
    input logic                 reset,
    meter_session_ctrl_if.slave bus
);
    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [CALC_W-1:0]  MAX_C      = CALC_W'(MAX_SEC);

    logic [3:0] sync_lvl;
    logic [3:0] sync_rise;
    logic [2:0] coin_rise;
    logic       coin_any;
    logic       start_lvl;
    logic       unused_sync;

    edge_sync #(.W(4)) u_edge_sync (
        .clk    (clk),
        .rst    (reset),
        .din_i  ({bus.sw_start, bus.sw_coin}),
        .lvl_o  (sync_lvl),
        .rise_o (sync_rise)
    );

    assign coin_rise   = sync_rise[2:0];
    assign coin_any    = |coin_rise;
    assign start_lvl   = sync_lvl[3];
    assign unused_sync = &{1'b0, sync_lvl[2:0], sync_rise[3]};

    meter_state_t        state_q, state_d;
    logic [CREDIT_W-1:0] time_q, time_d;
    logic [TICK_W-1:0]   presc_q, presc_d;
    logic [BLINK_W-1:0]  blink_q, blink_d;
    logic                blank_q, blank_d;

    logic [CALC_W-1:0] add_c;
    logic [CALC_W-1:0] fresh_c;
    logic [CALC_W-1:0] topup_c;
    logic [CALC_W-1:0] run_sum;
    logic [CALC_W-1:0] run_nxt;
    logic              tick;

    always_comb begin
        add_c = (coin_rise[0] ? CALC_W'(COIN0_SEC) : '0)
              + (coin_rise[1] ? CALC_W'(COIN1_SEC) : '0)
              + (coin_rise[2] ? CALC_W'(COIN2_SEC) : '0);
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        blink_d = blink_q;
        blank_d = blank_q;
        tick    = 1'b0;
        run_sum = '0;
        run_nxt = '0;
        fresh_c = sat_add('0, add_c, MAX_C);
        topup_c = sat_add({1'b0, time_q}, add_c, MAX_C);

        case (state_q)
            IDLE: begin
                time_d = '0;
                if (coin_any) begin
                    state_d = FUND;
                    time_d  = CREDIT_W'(fresh_c);
                    presc_d = '0;
                end
            end
            FUND: begin
                // Prescaler is left alone here so a pause resumes mid-second.
                time_d = CREDIT_W'(topup_c);
                if (start_lvl) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                tick    = (presc_q == TICK_LAST);
                presc_d = tick ? '0 : presc_q + TICK_W'(1);
                run_sum = {1'b0, time_q} + add_c;
                if (tick && run_sum != '0) begin
                    run_sum = run_sum - CALC_W'(1);
                end
                run_nxt = sat_add(run_sum, '0, MAX_C);
                time_d  = CREDIT_W'(run_nxt);
                if (run_nxt == '0) begin
                    state_d = EXPIRED;
                    blink_d = '0;
                    blank_d = 1'b0;
                end else if (!start_lvl) begin
                    state_d = FUND;
                end
            end
            EXPIRED: begin
                time_d = '0;
                if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                    blank_d = ~blank_q;
                end else begin
                    blink_d = blink_q + BLINK_W'(1);
                end
                if (coin_any) begin
                    state_d = FUND;
                    time_d  = CREDIT_W'(fresh_c);
                    presc_d = '0;
                    blink_d = '0;
                    blank_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            time_q  <= '0;
            presc_q <= '0;
            blink_q <= '0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            presc_q <= presc_d;
            blink_q <= blink_d;
            blank_q <= blank_d;
        end
    end

    assign bus.time_val = time_q;
    assign bus.state_o  = state_q;
    assign bus.running  = (state_q == RUN);
    assign bus.expired  = (state_q == EXPIRED);
    assign bus.blank    = blank_q;
endmodule
